// File: rtl/snake_pkg.sv
// snake_pkg: shared direction codes, button indices and game FSM states for the snake controller
package snake_pkg;
    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;
    localparam int BTN_CW    = 0;
    localparam int BTN_CCW   = 1;
    localparam int BTN_START = 2;
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, WAIT_DONE, PAUSE, OVER} state_t;
endpackage

// File: rtl/snake_btn_debounce.sv
// snake_btn_debounce: 2-FF synchroniser, stability filter and 1-cycle press pulse for one active-low key
module snake_btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic [1:0] sync;
    logic level;
    logic [CW-1:0] cnt;
    logic done;
    assign done = cnt == CW'(DB_CYCLES - 1);
    assign press = done && level && !sync[1];
    // track the synchronised key and adopt a new level only once it has held for DB_CYCLES clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) cnt <= '0;
            else if (done) begin
                level <= sync[1];
                cnt   <= '0;
            end else cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: button handling, move timing, turn queueing and game FSM for the snake datapath
// Optional SNAKE_CTRL_SPEEDUP_EN: step period halves every 8 points eaten, down to 1/8
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int TICK_DIV  = 33554432,
    parameter int DB_CYCLES = 1000000,
    parameter int SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         button,
    input  logic [3:0]         sw,
    input  logic               step_done,
    input  logic               collide,
    input  logic               eat,
    output logic               step,
    output logic [1:0]         dir,
    output logic               clear,
    output logic               running,
    output logic               game_over,
    output logic               blank,
    output logic [SCORE_W-1:0] score
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int PW = CW + 1;
    state_t state, state_nx;
    logic [2:0] press;
    logic [CW-1:0] cnt;
    logic [PW-1:0] period;
    logic term, pend_v, pend_cw, turn_v, turn_cw, do_step, unused_sw;
    genvar i;
    generate
        for (i = 0; i < 3; i++) begin : g_btn
            snake_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clk(clk), .rst(rst), .raw(button[i]), .press(press[i])
            );
        end
    endgenerate
`ifdef SNAKE_CTRL_SPEEDUP_EN
    logic [SCORE_W-1:0] lvl;
    assign lvl = score >> 3;
    assign period = (PW'(TICK_DIV) >> sw[1:0]) >> (lvl > SCORE_W'(3) ? 2'd3 : lvl[1:0]);
`else
    assign period = PW'(TICK_DIV) >> sw[1:0];
`endif
    assign term = PW'(cnt) == period - 1'b1;
    assign turn_v = pend_v | ((state == RUN || state == WAIT_DONE) && (press[BTN_CW] ^ press[BTN_CCW]));
    assign turn_cw = pend_v ? pend_cw : press[BTN_CW];
    assign clear = state == CLEAR;
    assign running = state == RUN || state == WAIT_DONE;
    assign game_over = state == OVER;
    assign unused_sw = ^sw[3:2];
    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next-state decode; a start press in RUN beats the terminal count
    always_comb begin
        state_nx = state;
        do_step = 1'b0;
        case (state)
            IDLE:      if (press[BTN_START]) state_nx = CLEAR;
            CLEAR:     state_nx = RUN;
            RUN:       if (press[BTN_START]) state_nx = PAUSE;
                       else if (term) begin
                           state_nx = WAIT_DONE;
                           do_step = 1'b1;
                       end
            WAIT_DONE: if (step_done) state_nx = collide ? OVER : RUN;
            PAUSE:     if (press[BTN_START]) state_nx = RUN;
            OVER:      if (press[BTN_START]) state_nx = CLEAR;
            default:   state_nx = IDLE;
        endcase
    end
    // tick counter, pending turn, direction, score and blink; CLEAR overrides everything last
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pend_v  <= 1'b0;
            pend_cw <= 1'b0;
            dir     <= DIR_RIGHT;
            score   <= '0;
            step    <= 1'b0;
            blank   <= 1'b0;
        end else begin
            step    <= do_step;
            pend_v  <= turn_v;
            pend_cw <= turn_cw;
            if (state == RUN && state_nx == RUN) cnt <= cnt + 1'b1;
            if (do_step) begin
                cnt    <= '0;
                pend_v <= 1'b0;
                if (turn_v) dir <= turn_cw ? dir - 1'b1 : dir + 1'b1;
            end
            if (state == WAIT_DONE && step_done && !collide && eat && score != '1) score <= score + 1'b1;
            if (state == OVER) begin
                if (press[BTN_START]) blank <= 1'b0;
                else if (term) begin
                    blank <= ~blank;
                    cnt   <= '0;
                end else cnt <= cnt + 1'b1;
            end
            if (state == CLEAR) begin
                cnt    <= '0;
                pend_v <= 1'b0;
                dir    <= DIR_RIGHT;
                score  <= '0;
                blank  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl: directed/randomised bench for snake_game_ctrl against a rule-level reference model
module tb_snake_game_ctrl;
    logic clk = 1'b0, rst = 1'b1, step_done = 1'b0, collide = 1'b0, eat = 1'b0;
    logic [2:0] button = 3'b111;
    logic [3:0] sw = 4'd0;
    logic step, clear, running, game_over, blank;
    logic [1:0] dir;
    logic [7:0] score;
    logic step2, clear2, running2, game_over2, blank2;
    logic [1:0] dir2, score2;
    int checks = 0, errors = 0;
    int t = 0, t_exp = -1, t_go = 0, t_blink = 0, t_blink_prev = 0;
    int n_step = 0, n_clear = 0, n_done = 0, n_blink = 0, cd = -1, fix_lat = 0, eat_mode = 0;
    bit auto_en = 1, nxt_collide = 0, run_q = 0, go_q = 0, blank_q = 0, clr_q = 0;
    int m_dir = 0, m_pend = 0, m_score = 0, m_score2 = 0;

    snake_game_ctrl #(.TICK_DIV(16), .DB_CYCLES(4), .SCORE_W(8)) u_dut (
        .clk(clk), .rst(rst), .button(button), .sw(sw), .step_done(step_done), .collide(collide),
        .eat(eat), .step(step), .dir(dir), .clear(clear), .running(running),
        .game_over(game_over), .blank(blank), .score(score)
    );
    snake_game_ctrl #(.TICK_DIV(16), .DB_CYCLES(4), .SCORE_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .button(button), .sw(sw), .step_done(step_done), .collide(collide),
        .eat(eat), .step(step2), .dir(dir2), .clear(clear2), .running(running2),
        .game_over(game_over2), .blank(blank2), .score(score2)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL global_timeout observed t=%0d expected finish", t);
        $fatal(1, "bench timed out");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mperiod();
        int p;
        p = 16 >> sw[1:0];
`ifdef SNAKE_CTRL_SPEEDUP_EN
        p = p >> ((m_score / 8) > 3 ? 3 : (m_score / 8));
`endif
        return p;
    endfunction

    task automatic fire();
        cd = -1;
        n_done++;
        step_done = 1'b1;
        if (nxt_collide) begin
            collide = 1'b1;
            eat = 1'b1;
            nxt_collide = 0;
            t_exp = -1;
        end else begin
            eat = (eat_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(eat_mode);
            if (eat) begin
                m_score = m_score < 255 ? m_score + 1 : 255;
                m_score2 = m_score2 < 3 ? m_score2 + 1 : 3;
            end
            t_exp = t + 1 + mperiod();
        end
    endtask

    task automatic on_step();
        n_step++;
        if (m_pend == 1) m_dir = (m_dir + 3) % 4;
        else if (m_pend == 2) m_dir = (m_dir + 1) % 4;
        m_pend = 0;
        chk("step_dir", dir, m_dir);
        if (t_exp >= 0) chk("step_time", t, t_exp);
        t_exp = -1;
        if (auto_en) cd = (fix_lat > 0 ? fix_lat : int'($urandom_range(1, 3))) - 1;
    endtask

    task automatic cyc1();
        @(negedge clk);
        t++;
        step_done = 1'b0;
        eat = 1'b0;
        collide = 1'b0;
        if (clear) begin
            n_clear++;
            m_dir = 0;
            m_pend = 0;
            m_score = 0;
            m_score2 = 0;
        end
        if (running && !run_q && clr_q) t_exp = t + mperiod();
        run_q = running;
        clr_q = clear;
        if (game_over && !go_q) t_go = t;
        go_q = game_over;
        if (blank !== blank_q) begin
            n_blink++;
            t_blink_prev = t_blink;
            t_blink = t;
        end
        blank_q = blank;
        if (cd == 0) fire();
        else if (cd > 0) cd--;
        if (step) on_step();
    endtask

    task automatic hold(input logic [2:0] low, input int n);
        for (int i = 0; i < n; i++) begin
            button = ~low;
            cyc1();
        end
    endtask

    task automatic model_turn(input logic [2:0] low);
        if (m_pend == 0 && (low == 3'b001 || low == 3'b010)) m_pend = (low == 3'b001) ? 1 : 2;
    endtask

    task automatic turn(input logic [2:0] low);
        model_turn(low);
        hold(low, 8);
        hold(3'b000, 8);
    endtask

    task automatic wait_step(input int max);
        int s0;
        s0 = n_step;
        for (int i = 0; i < max && n_step == s0; i++) cyc1();
        chk("step_seen", n_step != s0, 1);
    endtask

    task automatic run_until_done(input int k, input int max);
        int d0;
        d0 = n_done;
        for (int i = 0; i < max && n_done < d0 + k; i++) cyc1();
        chk("done_seen", n_done >= d0 + k, 1);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_step"}, step, 0);
        chk({tag, "_clear"}, clear, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_blank"}, blank, 0);
        chk({tag, "_dut2"}, {step2, clear2, dir2, running2, game_over2, blank2, score2}, 0);
    endtask

    initial begin
        int c0, s0;
        // reset from power-up
        hold(3'b000, 2);
        rst_chk("rst_init");
        rst = 1'b0;
        // start: one clear pulse, RUN, first step one full period later with dir 00
        c0 = n_clear;
        hold(3'b100, 8);
        hold(3'b000, 8);
        chk("start_clear_cnt", n_clear - c0, 1);
        chk("start_running", running, 1);
        wait_step(40);
        // turns: ccw, double cw (second ignored, also pressed during WAIT_DONE), simultaneous
        fix_lat = 12;
        turn(3'b010);
        wait_step(60);
        fix_lat = 0;
        model_turn(3'b001);
        hold(3'b001, 6);
        hold(3'b000, 6);
        model_turn(3'b001);
        hold(3'b001, 6);
        hold(3'b000, 6);
        wait_step(60);
        turn(3'b011);
        wait_step(60);
        for (int i = 0; i < 6; i++) begin
            logic [2:0] k;
            k = 3'($urandom_range(0, 3));
            if (k != 3'b000) turn(k);
            wait_step(60);
        end
        // score counting and 2-bit saturation
        eat_mode = 1;
        run_until_done(3, 200);
        hold(3'b000, 1);
        chk("score_3", score, m_score);
        chk("score2_3", score2, m_score2);
        run_until_done(2, 200);
        eat_mode = 0;
        hold(3'b000, 1);
        chk("score_5", score, m_score);
        chk("score2_sat", score2, m_score2);
        // fast speed select
        wait_step(60);
        sw = 4'b0010;
        eat_mode = 2;
        wait_step(40);
        wait_step(40);
        sw = 4'b0000;
        eat_mode = 0;
        // pause and resume
        wait_step(60);
        hold(3'b100, 8);
        t_exp = -1;
        hold(3'b000, 8);
        chk("pause_running", running, 0);
        s0 = n_step;
        hold(3'b000, 100);
        chk("pause_no_step", n_step - s0, 0);
        hold(3'b100, 8);
        hold(3'b000, 8);
        chk("resume_running", running, 1);
        wait_step(40);
        // game over: collide beats eat, blink every period, no steps
        nxt_collide = 1;
        s0 = m_score;
        run_until_done(1, 40);
        hold(3'b000, 2);
        chk("over_flag", game_over, 1);
        chk("over_running", running, 0);
        chk("over_score", score, s0);
        s0 = n_step;
        hold(3'b000, 40);
        chk("over_no_step", n_step - s0, 0);
        chk("blink_first", t_blink_prev, t_go + 16);
        chk("blink_second", t_blink, t_go + 32);
        c0 = n_clear;
        hold(3'b100, 8);
        hold(3'b000, 8);
        chk("restart_clear_cnt", n_clear - c0, 1);
        chk("restart_score", score, 0);
        chk("restart_dir", dir, 0);
        chk("restart_blank", blank, 0);
        chk("restart_game_over", game_over, 0);
        chk("restart_running", running, 1);
        // eight eats, then step intervals follow the score-dependent period
        eat_mode = 1;
        run_until_done(8, 400);
        eat_mode = 0;
        hold(3'b000, 1);
        chk("score_8", score, m_score);
        wait_step(40);
        wait_step(40);
        // reset while a step is outstanding; a stale step_done must be ignored
        hold(3'b000, 4);
        auto_en = 0;
        wait_step(60);
        hold(3'b000, 2);
        rst = 1'b1;
        hold(3'b000, 2);
        rst_chk("rst_wait");
        rst = 1'b0;
        m_dir = 0;
        m_pend = 0;
        m_score = 0;
        m_score2 = 0;
        t_exp = -1;
        s0 = n_step;
        step_done = 1'b1;
        eat = 1'b1;
        cyc1();
        hold(3'b000, 20);
        chk("stale_running", running, 0);
        chk("stale_score", score, 0);
        chk("stale_no_step", n_step - s0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
